// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory read-modify-write controller.
package mem_pkg;

  localparam int unsigned LSTYPE_W = 5;
  localparam int unsigned XLEN     = 32;

  localparam logic [LSTYPE_W-1:0] LS_B  = 5'b10000;
  localparam logic [LSTYPE_W-1:0] LS_H  = 5'b01000;
  localparam logic [LSTYPE_W-1:0] LS_W  = 5'b00100;
  localparam logic [LSTYPE_W-1:0] LS_BU = 5'b00010;
  localparam logic [LSTYPE_W-1:0] LS_HU = 5'b00001;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP, ERR} rmw_state_t;

  // Request fields kept for the duration of one transaction.
  typedef struct packed {
    logic                write;
    logic [LSTYPE_W-1:0] lstype;
    logic [1:0]          off;
    logic [XLEN-1:0]     wdata;
  } mem_req_t;

  // True when the access type/alignment combination is not serviceable.
  function automatic logic ls_fault(input logic [LSTYPE_W-1:0] lstype,
                                    input logic write,
                                    input logic [1:0] off);
    logic onehot;
    onehot = (lstype != '0) && ((lstype & (lstype - 5'd1)) == '0);
    return !onehot
        || (write && (lstype == LS_BU || lstype == LS_HU))
        || ((lstype == LS_H || lstype == LS_HU) && off[0])
        || ((lstype == LS_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Sub-word extraction (with extension) and store lane merge on a read word.
module mem_lane_fmt import mem_pkg::*; (
  input  logic [XLEN-1:0]     rd,
  input  logic [XLEN-1:0]     wdata,
  input  logic [LSTYPE_W-1:0] lstype,
  input  logic [1:0]          off,
  output logic [XLEN-1:0]     load_data,
  output logic [XLEN-1:0]     merge_word
);

  logic [XLEN-1:0] b_shift;
  logic [XLEN-1:0] h_shift;

  always_comb begin
    b_shift = rd >> {off, 3'b000};
    h_shift = rd >> {off[1], 4'b0000};
    unique case (lstype)
      LS_B:    load_data = {{24{b_shift[7]}}, b_shift[7:0]};
      LS_BU:   load_data = {24'h0, b_shift[7:0]};
      LS_H:    load_data = {{16{h_shift[15]}}, h_shift[15:0]};
      LS_HU:   load_data = {16'h0, h_shift[15:0]};
      LS_W:    load_data = rd;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merge_word = rd;
    unique case (lstype)
      LS_B:    merge_word[{off, 3'b000} +: 8]     = wdata[7:0];
      LS_H:    merge_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      LS_W:    merge_word = wdata;
      default: merge_word = rd;
    endcase
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage load/store responder doing sub-word RMW against a word-only SRAM.
module dmem_rmw_ctrl import mem_pkg::*; #(
  parameter int unsigned AW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [LSTYPE_W-1:0] req_lstype,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  rmw_state_t state_q, state_d;
  mem_req_t   req_q, req_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] load_data, merge_word;

  logic        req_ready_d, rsp_valid_d, rsp_err_d, mem_en_d, mem_we_d;
  logic [31:0] rsp_rdata_d, mem_wdata_d;
  logic [AW-1:0] mem_addr_d;

  logic accept_c, fault_c;
  logic unused_addr_hi;

  assign accept_c       = (state_q == IDLE) && req_valid;
  assign fault_c        = ls_fault(req_lstype, req_write, req_addr[1:0]);
  assign unused_addr_hi = &{1'b0, req_addr[31:AW+2]};

  // The read word is consumed in the same cycle it is captured.
  assign rd_d  = (state_q == CAP) ? mem_rdata : rd_q;
  assign req_d = accept_c ? mem_req_t'{req_write, req_lstype, req_addr[1:0], req_wdata} : req_q;

  mem_lane_fmt u_fmt (
    .rd         (rd_d),
    .wdata      (req_q.wdata),
    .lstype     (req_q.lstype),
    .off        (req_q.off),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept_c) begin
              if (fault_c)                                  state_d = ERR;
              else if (req_write && req_lstype == LS_W)     state_d = WR;
              else                                          state_d = RD;
            end
      RD:   state_d = CAP;
      CAP:  state_d = req_q.write ? WR : RSP;
      WR:   state_d = RSP;
      RSP:  state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP) || (state_d == ERR);
    rsp_err_d   = (state_d == ERR);
    rsp_rdata_d = ((state_d == RSP) && !req_q.write) ? load_data : '0;
    mem_en_d    = (state_d == RD) || (state_d == WR);
    mem_we_d    = (state_d == WR);
    mem_addr_d  = (accept_c && !fault_c) ? req_addr[AW+1:2] : mem_addr;
    mem_wdata_d = '0;
    if (state_d == WR) mem_wdata_d = (state_q == IDLE) ? req_wdata : merge_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      rd_q      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      req_q     <= req_d;
      rd_q      <= rd_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

endmodule
